// File: rtl/dsm_quant_multibit_pkg.sv
// Shared definitions for the multibit delta-sigma quantizer: overload FSM
// state encoding plus idle-code and feedback-scale helpers.
package dsm_quant_multibit_pkg;

    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_OVERLOAD = 2'd1,
        ST_RECOVER  = 2'd2
    } ovl_state_e;

    function automatic int idle_hi(input int qb);
        return 32'sd1 << (qb - 32'sd1);
    endfunction

    function automatic int idle_lo(input int qb);
        return idle_hi(qb) - 32'sd1;
    endfunction

    // Offset that centres the offset-binary code around zero.
    function automatic int fb_offset(input int qb);
        return (32'sd1 << qb) - 32'sd1;
    endfunction

    function automatic int fb_shift(input int w, input int qb);
        return w - 32'sd1 - qb;
    endfunction

endpackage

// File: rtl/dsm_quant_multibit_chan.sv
// One quantizer channel: code/feedback generation and the
// RUN -> OVERLOAD -> RECOVER integrator-protection FSM.
module dsm_quant_chan
    import dsm_quant_multibit_pkg::*;
#(
    parameter int W           = 34,
    parameter int QB          = 1,
    parameter int OVL_LIMIT   = 16,
    parameter int RECOVER_LEN = 64
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          en,
    input  logic          mute,
    input  logic [QB-1:0] idle_code,
    input  logic [W-1:0]  sigma,
    output logic [QB-1:0] code,
    output logic [W-1:0]  fb,
    output logic          ovl,
    output logic          clr
);

    localparam logic [QB-1:0] IDLE_HI = QB'(idle_hi(QB));

    function automatic logic [W-1:0] fb_of(input logic [QB-1:0] c);
        int lvl;
        lvl = 32'sd2 * int'(c) - fb_offset(QB);
        return W'(lvl) << fb_shift(W, QB);
    endfunction

    ovl_state_e    state_r, state_n_s;
    logic [7:0]    ocnt_r, ocnt_n_s, rcnt_r, rcnt_n_s;
    logic [QB-1:0] raw_code_s, emit_s, code_r;
    logic [W-1:0]  fb_r;
    logic          oor_s, use_idle_s, ovl_r, clr_r;

    assign raw_code_s = sigma[W-1 -: QB] ^ (QB'(1'b1) << (QB - 1));
    assign oor_s      = sigma[W-1] ^ sigma[W-2];

    // Next-state, counter and emitted-code selection for one strobe.
    always_comb begin
        state_n_s  = state_r;
        ocnt_n_s   = ocnt_r;
        rcnt_n_s   = rcnt_r;
        use_idle_s = 1'b0;
        case (state_r)
            ST_RUN: begin
                if (oor_s) begin
                    ocnt_n_s = ocnt_r + 8'd1;
                    if (ocnt_r + 8'd1 == 8'(OVL_LIMIT)) begin
                        state_n_s = ST_OVERLOAD;
                    end else begin
                        state_n_s = ST_RUN;
                    end
                end else begin
                    ocnt_n_s = 8'd0;
                end
            end
            ST_OVERLOAD: begin
                use_idle_s = 1'b1;
                state_n_s  = ST_RECOVER;
                rcnt_n_s   = 8'(RECOVER_LEN);
            end
            ST_RECOVER: begin
                use_idle_s = 1'b1;
                rcnt_n_s   = rcnt_r - 8'd1;
                if (rcnt_r == 8'd1) begin
                    state_n_s = ST_RUN;
                    ocnt_n_s  = 8'd0;
                end else begin
                    state_n_s = ST_RECOVER;
                end
            end
            default: begin
                state_n_s = ST_RUN;
                ocnt_n_s  = 8'd0;
                rcnt_n_s  = 8'd0;
            end
        endcase
        if (use_idle_s || mute) begin
            emit_s = idle_code;
        end else begin
            emit_s = raw_code_s;
        end
    end

    // State and registered outputs; clear request lasts exactly one cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= ST_RUN;
            ocnt_r  <= 8'd0;
            rcnt_r  <= 8'd0;
            code_r  <= IDLE_HI;
            fb_r    <= fb_of(IDLE_HI);
            ovl_r   <= 1'b0;
            clr_r   <= 1'b0;
        end else begin
            clr_r <= 1'b0;
            if (en) begin
                state_r <= state_n_s;
                ocnt_r  <= ocnt_n_s;
                rcnt_r  <= rcnt_n_s;
                code_r  <= emit_s;
                fb_r    <= fb_of(emit_s);
                ovl_r   <= (state_n_s != ST_RUN);
                clr_r   <= (state_r == ST_RUN) && (state_n_s == ST_OVERLOAD);
            end
        end
    end

    assign code = code_r;
    assign fb   = fb_r;
    assign ovl  = ovl_r;
    assign clr  = clr_r;

endmodule

// File: rtl/dsm_quant_multibit.sv
// Multichannel delta-sigma quantizer top: shared idle toggle and VALID_O,
// one dsm_quant_chan per channel.
module dsm_quant_multibit
    import dsm_quant_multibit_pkg::*;
#(
    parameter int PCM_Bit_Length = 32,
    parameter int QUANT_BITS     = 1,
    parameter int CHANNELS       = 2,
    parameter int OVL_LIMIT      = 16,
    parameter int RECOVER_LEN    = 64
) (
    input  logic                                     CLK_I,
    input  logic                                     RESET_I,
    input  logic                                     EN_I,
    input  logic                                     MUTE_I,
    input  logic [CHANNELS*(PCM_Bit_Length+2)-1:0]   SIGMA_DATA_I,
    output logic [CHANNELS*QUANT_BITS-1:0]           QUANT_DATA_O,
    output logic [CHANNELS*(PCM_Bit_Length+2)-1:0]   FB_DATA_O,
    output logic                                     VALID_O,
    output logic [CHANNELS-1:0]                      OVL_O,
    output logic [CHANNELS-1:0]                      CLR_O
);

    localparam int W = PCM_Bit_Length + 2;
    localparam logic [QUANT_BITS-1:0] IDLE_HI = QUANT_BITS'(idle_hi(QUANT_BITS));
    localparam logic [QUANT_BITS-1:0] IDLE_LO = QUANT_BITS'(idle_lo(QUANT_BITS));

    logic                  tog_r, valid_r;
    logic [QUANT_BITS-1:0] idle_code_s;

    assign idle_code_s = tog_r ? IDLE_HI : IDLE_LO;

    // Idle toggle advances on every strobe, valid follows the strobe by one cycle.
    always_ff @(posedge CLK_I or posedge RESET_I) begin
        if (RESET_I) begin
            tog_r   <= 1'b1;
            valid_r <= 1'b0;
        end else begin
            valid_r <= EN_I;
            if (EN_I) begin
                tog_r <= ~tog_r;
            end
        end
    end

    assign VALID_O = valid_r;

    for (genvar c = 0; c < CHANNELS; c++) begin : g_chan
        dsm_quant_chan #(
            .W           (W),
            .QB          (QUANT_BITS),
            .OVL_LIMIT   (OVL_LIMIT),
            .RECOVER_LEN (RECOVER_LEN)
        ) u_chan (
            .clk       (CLK_I),
            .rst       (RESET_I),
            .en        (EN_I),
            .mute      (MUTE_I),
            .idle_code (idle_code_s),
            .sigma     (SIGMA_DATA_I[c*W +: W]),
            .code      (QUANT_DATA_O[c*QUANT_BITS +: QUANT_BITS]),
            .fb        (FB_DATA_O[c*W +: W]),
            .ovl       (OVL_O[c]),
            .clr       (CLR_O[c])
        );
    end

endmodule
